// File: rtl/me_pkg.sv
// Shared definitions for the integer motion estimation back end: default
// widths, the selector FSM states and the coding-block (abs_Control) indices.
package me_pkg;

    localparam int DEF_SAD_W = 16;
    localparam int DEF_COL_W = 5;
    localparam int DEF_ROW_W = 7;

    localparam int NUM_CB = 4;

    // Sub-block indices follow the PE array controller's abs_Control encoding.
    localparam logic [1:0] CB1 = 2'd0;
    localparam logic [1:0] CB2 = 2'd1;
    localparam logic [1:0] CB3 = 2'd2;
    localparam logic [1:0] CB4 = 2'd3;

    localparam logic [1:0] FIRST_CB = CB1;
    localparam logic [1:0] LAST_CB  = CB4;

    localparam logic [DEF_SAD_W-1:0] SAD_INIT = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_e;

endpackage

// File: rtl/sad_min_entry.sv
// One sub-block's running best candidate: minimum SAD, its column/row and a
// hit flag. The read port shows next-state values so same-cycle updates are seen.
module sad_min_entry
    import me_pkg::*;
#(
    parameter int SAD_W = DEF_SAD_W,
    parameter int COL_W = DEF_COL_W,
    parameter int ROW_W = DEF_ROW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [SAD_W-1:0] sad_in,
    input  logic [COL_W-1:0] col_in,
    input  logic [ROW_W-1:0] row_in,
    output logic [SAD_W-1:0] rd_sad,
    output logic [COL_W-1:0] rd_col,
    output logic [ROW_W-1:0] rd_row,
    output logic             rd_hit
);

    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [COL_W-1:0] best_col_q, best_col_d;
    logic [ROW_W-1:0] best_row_q, best_row_d;
    logic             hit_q, hit_d;

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        best_sad_d = best_sad_q;
        best_col_d = best_col_q;
        best_row_d = best_row_q;
        hit_d      = hit_q;
        if (clr) begin
            best_sad_d = '1;
            best_col_d = '0;
            best_row_d = '0;
            hit_d      = 1'b0;
        end else if (wr_en) begin
            hit_d = 1'b1;
            // Strict compare: on a tie the earlier candidate is kept.
            if (sad_in < best_sad_q) begin
                best_sad_d = sad_in;
                best_col_d = col_in;
                best_row_d = row_in;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; these few
    // registers are reset explicitly because their init value is architectural.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_sad_q <= '1;
            best_col_q <= '0;
            best_row_q <= '0;
            hit_q      <= 1'b0;
        end else begin
            best_sad_q <= best_sad_d;
            best_col_q <= best_col_d;
            best_row_q <= best_row_d;
            hit_q      <= hit_d;
        end
    end

    assign rd_sad = best_sad_d;
    assign rd_col = best_col_d;
    assign rd_row = best_row_d;
    assign rd_hit = hit_d;

endmodule

// File: rtl/sad_min_select.sv
// Tracks the minimum SAD and motion vector for the four 16x16 sub-blocks of a
// 32x32 CU, then streams the four results out over a valid/ready handshake.
module sad_min_select
    import me_pkg::*;
#(
    parameter int SAD_W = DEF_SAD_W,
    parameter int COL_W = DEF_COL_W,
    parameter int ROW_W = DEF_ROW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad_in,
    input  logic [1:0]       cb_id,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    input  logic             search_done,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_cb,
    output logic [SAD_W-1:0] out_sad,
    output logic [COL_W-1:0] out_col,
    output logic [ROW_W-1:0] out_row,
    output logic             out_hit,
    output logic             out_last,
    output logic             drop_err
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_cb_q, out_cb_d;
    logic [SAD_W-1:0] out_sad_q, out_sad_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic             out_hit_q, out_hit_d;
    logic             out_last_q, out_last_d;
    logic             drop_err_q, drop_err_d;

    logic             clr;
    logic             acc_wr;

    logic [SAD_W-1:0] ent_sad [NUM_CB];
    logic [COL_W-1:0] ent_col [NUM_CB];
    logic [ROW_W-1:0] ent_row [NUM_CB];
    logic             ent_hit [NUM_CB];

    for (genvar i = 0; i < NUM_CB; i++) begin : g_entry
        sad_min_entry #(
            .SAD_W (SAD_W),
            .COL_W (COL_W),
            .ROW_W (ROW_W)
        ) u_entry (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .wr_en  (acc_wr && (cb_id == 2'(i))),
            .sad_in (sad_in),
            .col_in (col),
            .row_in (row),
            .rd_sad (ent_sad[i]),
            .rd_col (ent_col[i]),
            .rd_row (ent_row[i]),
            .rd_hit (ent_hit[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        out_cb_d   = out_cb_q;
        drop_err_d = drop_err_q;
        clr        = 1'b0;
        acc_wr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (start) begin
                    clr = 1'b1;
                end else begin
                    acc_wr = sad_valid;
                    if (search_done) begin
                        state_d  = OUTPUT;
                        out_cb_d = FIRST_CB;
                    end
                end
            end
            OUTPUT: begin
                if (out_valid_q && out_ready) begin
                    if (out_cb_q == LAST_CB) begin
                        state_d  = IDLE;
                        out_cb_d = FIRST_CB;
                    end else begin
                        out_cb_d = out_cb_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            drop_err_d = 1'b0;
        end
        if (sad_valid && (state_q != ACCUM)) begin
            drop_err_d = 1'b1;
        end

        // Payload is loaded from entry next-state so a SAD arriving with
        // search_done is already reflected in the first beat.
        out_valid_d = (state_d == OUTPUT);
        out_sad_d   = '0;
        out_col_d   = '0;
        out_row_d   = '0;
        out_hit_d   = 1'b0;
        out_last_d  = 1'b0;
        if (out_valid_d) begin
            out_sad_d  = ent_sad[out_cb_d];
            out_col_d  = ent_col[out_cb_d];
            out_row_d  = ent_row[out_cb_d];
            out_hit_d  = ent_hit[out_cb_d];
            out_last_d = (out_cb_d == LAST_CB);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_cb_q    <= '0;
            out_sad_q   <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            out_hit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_cb_q    <= out_cb_d;
            out_sad_q   <= out_sad_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            out_hit_q   <= out_hit_d;
            out_last_q  <= out_last_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_cb    = out_cb_q;
    assign out_sad   = out_sad_q;
    assign out_col   = out_col_q;
    assign out_row   = out_row_q;
    assign out_hit   = out_hit_q;
    assign out_last  = out_last_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_sad_min_select.sv
// Self-checking bench for sad_min_select: directed sequences, a vector table
// and randomized CU searches scored against a candidate-list reference model.
module tb_sad_min_select;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sad_valid;
    logic [15:0] sad_in;
    logic [1:0]  cb_id;
    logic [4:0]  col;
    logic [6:0]  row;
    logic        search_done;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_cb;
    logic [15:0] out_sad;
    logic [4:0]  out_col;
    logic [6:0]  out_row;
    logic        out_hit;
    logic        out_last;
    logic        drop_err;

    sad_min_select dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sad_valid   (sad_valid),
        .sad_in      (sad_in),
        .cb_id       (cb_id),
        .col         (col),
        .row         (row),
        .search_done (search_done),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_cb      (out_cb),
        .out_sad     (out_sad),
        .out_col     (out_col),
        .out_row     (out_row),
        .out_hit     (out_hit),
        .out_last    (out_last),
        .drop_err    (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cb;
        logic [15:0] sad;
        logic [4:0]  col;
        logic [6:0]  row;
    } cand_t;

    typedef struct {
        cand_t       in;
        logic [15:0] e_sad;
        logic [4:0]  e_col;
        logic [6:0]  e_row;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    cand_t cands[$];
    vec_t  vecs[4];

    logic [15:0] got_sad [4];
    logic [4:0]  got_col [4];
    logic [6:0]  got_row [4];
    logic        got_hit [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the result for a sub-block is the smallest SAD seen for it;
    // its vector is that of the earliest candidate achieving that minimum,
    // unless the minimum equals the all-ones init value (never beaten).
    function automatic void ref_result(input int cb, output logic [15:0] s,
                                       output logic [4:0] c, output logic [6:0] r,
                                       output logic h);
        logic [15:0] m = 16'hFFFF;
        bit found = 0;
        h = 0; c = '0; r = '0;
        foreach (cands[i]) if (cands[i].cb == 2'(cb)) begin
            h = 1;
            if (cands[i].sad < m) m = cands[i].sad;
        end
        if (m != 16'hFFFF)
            foreach (cands[i])
                if (!found && cands[i].cb == 2'(cb) && cands[i].sad == m) begin
                    c = cands[i].col; r = cands[i].row; found = 1;
                end
        s = m;
    endfunction

    task automatic start_cu();
        start = 1'b1;
        tick();
        start = 1'b0;
        cands.delete();
    endtask

    task automatic put(input bit v, input logic [1:0] cb, input logic [15:0] s,
                       input logic [4:0] c, input logic [6:0] r, input bit done);
        cand_t e;
        sad_valid = v; cb_id = cb; sad_in = s; col = c; row = r; search_done = done;
        if (v) begin
            e.cb = cb; e.sad = s; e.col = c; e.row = r;
            cands.push_back(e);
        end
        tick();
        sad_valid = 1'b0;
        search_done = 1'b0;
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1,1,0,1 then 1; 2: random.
    task automatic drain(input int mode, input bit use_model);
        bit          pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int          k = 0;
        int          cyc = 0;
        bit          stalled = 0;
        logic [31:0] held = '0;
        logic [15:0] es; logic [4:0] ec; logic [6:0] er; logic eh;
        check("first_valid", {31'd0, out_valid}, 32'd1);
        while (k < 4 && cyc < 60) begin
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = (cyc < 7) ? pat[cyc] : 1'b1;
            else                out_ready = 1'($urandom_range(0, 1));
            if (stalled)
                check("stall_hold", {out_cb, out_sad, out_col, out_row, out_hit, out_last}, held);
            if (out_valid && out_ready) begin
                check("beat_cb", {30'd0, out_cb}, k);
                check("beat_last", {31'd0, out_last}, {31'd0, (k == 3)});
                got_sad[k] = out_sad; got_col[k] = out_col;
                got_row[k] = out_row; got_hit[k] = out_hit;
                k++;
                stalled = 0;
            end else begin
                stalled = out_valid;
                held = {out_cb, out_sad, out_col, out_row, out_hit, out_last};
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("beats_transferred", k, 4);
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        if (use_model)
            for (int i = 0; i < 4; i++) begin
                ref_result(i, es, ec, er, eh);
                check($sformatf("cb%0d_sad", i), got_sad[i], es);
                check($sformatf("cb%0d_col", i), got_col[i], ec);
                check($sformatf("cb%0d_row", i), got_row[i], er);
                check($sformatf("cb%0d_hit", i), got_hit[i], eh);
            end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sad_valid = 1'b0; sad_in = '0; cb_id = '0;
        col = '0; row = '0; search_done = 1'b0; out_ready = 1'b0;

        vecs[0] = '{in: '{cb: 2'd0, sad: 16'h0000, col: 5'd31, row: 7'd127}, e_sad: 16'h0000, e_col: 5'd31, e_row: 7'd127};
        vecs[1] = '{in: '{cb: 2'd3, sad: 16'hFFFF, col: 5'd7,  row: 7'd9},   e_sad: 16'hFFFF, e_col: 5'd0,  e_row: 7'd0};
        vecs[2] = '{in: '{cb: 2'd1, sad: 16'hFFFE, col: 5'd1,  row: 7'd1},   e_sad: 16'hFFFE, e_col: 5'd1,  e_row: 7'd1};
        vecs[3] = '{in: '{cb: 2'd2, sad: 16'h1234, col: 5'd16, row: 7'd64},  e_sad: 16'h1234, e_col: 5'd16, e_row: 7'd64};

        tick(); tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_sad", {16'd0, out_sad}, 0);
        check("rst_hit_last", {30'd0, out_hit, out_last}, 0);
        check("rst_drop_err", {31'd0, drop_err}, 0);

        // Ties keep the first-found candidate.
        start_cu();
        check("accum_busy", {31'd0, busy}, 1);
        put(1, 2'd0, 16'd500, 5'd3, 7'd10, 0);
        put(1, 2'd0, 16'd300, 5'd4, 7'd12, 0);
        put(1, 2'd0, 16'd300, 5'd5, 7'd2, 0);
        put(0, 2'd0, 16'd0, 5'd0, 7'd0, 1);
        drain(0, 1);
        check("tie_sad", got_sad[0], 300);
        check("tie_col_row", {got_col[0], got_row[0]}, {5'd4, 7'd12});
        check("miss_cb3", {got_hit[3], got_sad[3]}, {1'b0, 16'hFFFF});

        // Back-to-back to CB2, final candidate together with search_done.
        start_cu();
        put(1, 2'd2, 16'd900, 5'd1, 7'd1, 0);
        put(1, 2'd2, 16'd700, 5'd2, 7'd2, 0);
        put(1, 2'd2, 16'd800, 5'd3, 7'd3, 0);
        put(1, 2'd2, 16'd650, 5'd4, 7'd4, 0);
        put(1, 2'd2, 16'd640, 5'd9, 7'd33, 1);
        drain(0, 1);
        check("b2b_sad", got_sad[2], 640);
        check("b2b_col_row", {got_col[2], got_row[2]}, {5'd9, 7'd33});

        // Stalling consumer.
        start_cu();
        put(1, 2'd1, 16'd42, 5'd6, 7'd7, 0);
        put(1, 2'd3, 16'd17, 5'd8, 7'd90, 0);
        put(1, 2'd0, 16'd99, 5'd30, 7'd100, 1);
        drain(1, 1);

        // Stray SAD while idle.
        sad_valid = 1'b1; cb_id = 2'd0; sad_in = 16'd5;
        tick();
        sad_valid = 1'b0;
        check("drop_set", {31'd0, drop_err}, 1);
        search_done = 1'b1;
        tick(); tick();
        search_done = 1'b0;
        check("drop_sticky", {31'd0, drop_err}, 1);
        check("idle_done_ignored", {31'd0, busy}, 0);
        start_cu();
        check("drop_cleared", {31'd0, drop_err}, 0);
        put(0, 2'd0, 16'd0, 5'd0, 7'd0, 1);
        drain(0, 1);

        // Restart mid-ACCUM discards earlier results.
        start_cu();
        put(1, 2'd1, 16'd100, 5'd2, 7'd3, 0);
        start_cu();
        put(1, 2'd2, 16'd77, 5'd3, 7'd3, 1);
        drain(0, 1);
        check("restart_cb1", {got_hit[1], got_sad[1]}, {1'b0, 16'hFFFF});

        // Reset mid-OUTPUT while stalled.
        start_cu();
        put(1, 2'd0, 16'd50, 5'd1, 7'd2, 1);
        out_ready = 1'b0;
        tick();
        check("pre_rst_valid", {31'd0, out_valid}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_out_busy", {31'd0, busy}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_payload", {out_cb, out_sad, out_col, out_row, out_hit, out_last}, 0);

        // Single-candidate vector table, including the boundary SAD values.
        foreach (vecs[v]) begin
            start_cu();
            put(1, vecs[v].in.cb, vecs[v].in.sad, vecs[v].in.col, vecs[v].in.row, 1);
            drain(0, 0);
            for (int i = 0; i < 4; i++) begin
                if (2'(i) == vecs[v].in.cb) begin
                    check($sformatf("vec%0d_hit", v), {31'd0, got_hit[i]}, 1);
                    check($sformatf("vec%0d_res", v), {got_sad[i], got_col[i], got_row[i]},
                          {vecs[v].e_sad, vecs[v].e_col, vecs[v].e_row});
                end else begin
                    check($sformatf("vec%0d_miss%0d", v, i), {got_hit[i], got_sad[i]}, {1'b0, 16'hFFFF});
                end
            end
        end

        // Randomized searches.
        for (int t = 0; t < 30; t++) begin
            int  n = $urandom_range(0, 12);
            bit  merged = 0;
            start_cu();
            for (int i = 0; i < n; i++) begin
                logic [15:0] s;
                if ($urandom_range(0, 3) == 0) put(0, 2'd0, 16'd0, 5'd0, 7'd0, 0);
                s = ($urandom_range(0, 2) != 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
                merged = (i == n - 1) && ($urandom_range(0, 1) == 1);
                put(1, 2'($urandom_range(0, 3)), s, 5'($urandom), 7'($urandom), merged);
            end
            if (!merged) put(0, 2'd0, 16'd0, 5'd0, 7'd0, 1);
            drain(2, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
